// File: rtl/ram_window_display.sv
// Dual-port RAM with touchscreen-driven port A and a windowed port-B scanner feeding the LCD.
// Define RAM_WINDOW_AUTOINC_EN to advance addr by one word after every commit with wen!=0.
module ram_window_display #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int WINDOW  = 4,
  parameter int REFRESH = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W/8-1:0] wen,
  input  logic [1:0]          input_sel,
  input  logic                input_valid,
  input  logic [31:0]         input_value,
  input  logic [5:0]          display_number,
  output logic                display_valid,
  output logic [39:0]         display_name,
  output logic [31:0]         display_value,
  output logic [DATA_W/8-1:0] led_wen,
  output logic [3:0]          led_sel,
  output logic                scan_busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CNT_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  typedef enum logic [1:0] {S_SCAN, S_LAST, S_WAIT} state_t;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [31:0]       addr, base;
  logic [DATA_W-1:0] wdata, rdata, q_b;
  logic [DATA_W-1:0] win_buf [WINDOW];
  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] a_word, b_word;
  logic              commit, base_load;
  logic              nxt_valid;
  logic [39:0]       nxt_name;
  logic [31:0]       nxt_value;

  assign commit    = input_valid && (input_sel == 2'd3);
  assign base_load = input_valid && (input_sel == 2'd2);
  assign a_word    = addr[ADDR_W+1:2];
  assign b_word    = base[ADDR_W+1:2] + ADDR_W'(idx);
  assign led_wen   = wen;
  assign led_sel   = 4'b0001 << input_sel;

  // Both ports read-first: NBA write and read of the same word in one edge return old data.
  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wen[i]) mem[a_word][i*8 +: 8] <= input_value[i*8 +: 8];
      end
    end
    q_b <= mem[b_word];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr  <= '0;
      wdata <= '0;
      base  <= '0;
      rdata <= '0;
    end else begin
      rdata <= mem[a_word];
      if (input_valid) begin
        case (input_sel)
          2'd0: addr  <= {input_value[31:2], 2'b00};
          2'd1: wdata <= input_value[DATA_W-1:0];
          2'd2: base  <= {input_value[31:2], 2'b00};
          default: begin
            wdata <= input_value[DATA_W-1:0];
`ifdef RAM_WINDOW_AUTOINC_EN
            if (|wen) addr <= {addr[31:ADDR_W+2], addr[ADDR_W+1:0] + (ADDR_W+2)'(4)};
`endif
          end
        endcase
      end
    end
  end

  // A base load abandons the pass outright; the in-flight capture of that edge is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_SCAN;
      idx       <= '0;
      cnt       <= '0;
      scan_busy <= 1'b1;
      for (int unsigned n = 0; n < WINDOW; n++) win_buf[n] <= '0;
    end else if (base_load) begin
      state     <= S_SCAN;
      idx       <= '0;
      scan_busy <= 1'b1;
    end else begin
      case (state)
        S_SCAN: begin
          if (idx != '0) win_buf[idx - 1'b1] <= q_b;
          if (idx == IDX_W'(WINDOW - 1)) state <= S_LAST;
          else                           idx   <= idx + 1'b1;
        end
        S_LAST: begin
          win_buf[WINDOW-1] <= q_b;
          cnt               <= CNT_W'(REFRESH - 1);
          state             <= S_WAIT;
          scan_busy         <= 1'b0;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            idx       <= '0;
            state     <= S_SCAN;
            scan_busy <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= S_SCAN;
          idx       <= '0;
          scan_busy <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    nxt_valid = 1'b0;
    nxt_name  = '0;
    nxt_value = '0;
    case (display_number)
      6'd1: begin nxt_valid = 1'b1; nxt_name = "ADDR "; nxt_value = addr;        end
      6'd2: begin nxt_valid = 1'b1; nxt_name = "WDATA"; nxt_value = 32'(wdata);  end
      6'd3: begin nxt_valid = 1'b1; nxt_name = "RDATA"; nxt_value = 32'(rdata);  end
      6'd4: begin nxt_valid = 1'b1; nxt_name = "BASE "; nxt_value = base;        end
      default: begin
        for (int unsigned n = 0; n < WINDOW; n++) begin
          if (display_number == 6'(n + 5)) begin
            nxt_valid = 1'b1;
            nxt_name  = {"WIN", 8'(48 + n), " "};
            nxt_value = 32'(win_buf[n]);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= nxt_valid;
      display_name  <= nxt_name;
      display_value <= nxt_value;
    end
  end

endmodule

// File: tb/tb_ram_window_display.sv
// Randomized scoreboard bench for ram_window_display against a word-level reference model.
`timescale 1ns/1ps
module tb_ram_window_display;
  localparam int W      = 4;
  localparam int RF     = 8;
  localparam int PERIOD = W + 1 + RF;
  localparam int SETTLE = PERIOD + W + 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  wen = '0;
  logic [1:0]  input_sel = '0;
  logic        input_valid = 1'b0;
  logic [31:0] input_value = '0;
  logic [5:0]  display_number = '0;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic [3:0]  led_wen;
  logic [3:0]  led_sel;
  logic        scan_busy;

  ram_window_display #(.DATA_W(32), .ADDR_W(8), .WINDOW(W), .REFRESH(RF)) dut (
    .clk(clk), .reset(reset), .wen(wen), .input_sel(input_sel),
    .input_valid(input_valid), .input_value(input_value),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value),
    .led_wen(led_wen), .led_sel(led_sel), .scan_busy(scan_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  slot;
    logic        v;
    logic [39:0] name;
    logic [31:0] value;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  // Reference model: word-addressed RAM, user registers, scan phase within a pass period.
  logic [31:0] m_ram [256];
  logic [31:0] m_addr, m_wdata, m_base, m_rdata;
  int phase = 0, cyc = 0, last_dist = 0, since_rst = 1000000;
  bit base_since_rst = 1'b1;

  function automatic bit settled();
    return (cyc - last_dist) >= SETTLE;
  endfunction

  // Window slot n is known once a full pass follows the last disturbance, or while still zero after reset.
  function automatic bit win_known(int n);
    return settled() || (!base_since_rst && since_rst <= n + 1);
  endfunction

  function automatic exp_t expect_for(logic [5:0] s);
    exp_t e;
    int n;
    logic [7:0] wi;
    e.slot = s; e.v = 1'b0; e.name = '0; e.value = '0; e.busy = 1'b0;
    case (s)
      6'd1: begin e.v = 1'b1; e.name = "ADDR "; e.value = m_addr;  end
      6'd2: begin e.v = 1'b1; e.name = "WDATA"; e.value = m_wdata; end
      6'd3: begin e.v = 1'b1; e.name = "RDATA"; e.value = m_rdata; end
      6'd4: begin e.v = 1'b1; e.name = "BASE "; e.value = m_base;  end
      default: begin
        if (s >= 6'd5 && s < 6'(5 + W)) begin
          n = int'(s) - 5;
          wi = m_base[9:2] + 8'(n);
          e.v = 1'b1;
          e.name = {"WIN", 8'(48 + n), " "};
          e.value = settled() ? m_ram[wi] : 32'h0;
        end
      end
    endcase
    return e;
  endfunction

  function automatic logic [5:0] pick_slot();
    int s;
    s = $urandom_range(0, 63);
    if (s >= 5 && s < 5 + W && !win_known(s - 5)) s = $urandom_range(1, 4);
    return 6'(s);
  endfunction

  task automatic model_edge(bit v, logic [1:0] sel, logic [31:0] val, logic [3:0] we, bit rst);
    logic [7:0] w;
    cyc++;
    if (rst) begin
      m_addr = '0; m_wdata = '0; m_base = '0; m_rdata = '0;
      phase = 0; last_dist = cyc; since_rst = 0; base_since_rst = 1'b0;
      return;
    end
    since_rst++;
    m_rdata = m_ram[m_addr[9:2]];
    phase = (phase + 1) % PERIOD;
    if (v) begin
      case (sel)
        2'd0: m_addr = {val[31:2], 2'b00};
        2'd1: m_wdata = val;
        2'd2: begin
          m_base = {val[31:2], 2'b00};
          phase = 0; last_dist = cyc; base_since_rst = 1'b1;
        end
        default: begin
          m_wdata = val;
          w = m_addr[9:2];
          for (int b = 0; b < 4; b++) if (we[b]) m_ram[w][8*b +: 8] = val[8*b +: 8];
          if (we != 4'h0) begin
            last_dist = cyc;
`ifdef RAM_WINDOW_AUTOINC_EN
            m_addr = {m_addr[31:10], m_addr[9:0] + 10'd4};
`endif
          end
        end
      endcase
    end
  endtask

  task automatic step(bit v, logic [1:0] sel, logic [31:0] val, logic [3:0] we, logic [5:0] slot, bit rst);
    exp_t e;
    reset = rst; input_valid = v; input_sel = sel; input_value = val; wen = we;
    display_number = slot;
    e = expect_for(slot);
    @(posedge clk);
    model_edge(v, sel, val, we, rst);
    if (rst) begin e.v = 1'b0; e.name = '0; e.value = '0; end
    e.busy = (phase < W + 1);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 2'($urandom), $urandom, 4'($urandom), pick_slot(), 1'b0);
  endtask

  task automatic ld(logic [1:0] sel, logic [31:0] val);
    step(1'b1, sel, val, 4'h0, pick_slot(), 1'b0);
  endtask

  task automatic cm(logic [31:0] val, logic [3:0] we);
    step(1'b1, 2'd3, val, we, pick_slot(), 1'b0);
  endtask

  task automatic show(logic [5:0] s);
    step(1'b0, 2'd0, 32'h0, 4'h0, s, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, 32'h0, 4'h0, pick_slot(), 1'b1);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      total++;
      if ({display_valid, display_name, display_value} !== {mon_e.v, mon_e.name, mon_e.value}) begin
        bad++;
        $display("FAIL display slot=%0d: got valid=%0b name=%h value=%h, want valid=%0b name=%h value=%h",
                 mon_e.slot, display_valid, display_name, display_value, mon_e.v, mon_e.name, mon_e.value);
      end
      total++;
      if (scan_busy !== mon_e.busy) begin
        bad++;
        $display("FAIL scan_busy: got %0b want %0b", scan_busy, mon_e.busy);
      end
    end
    total++;
    if (led_sel !== (4'b0001 << input_sel)) begin
      bad++;
      $display("FAIL led_sel: got %b want %b", led_sel, 4'b0001 << input_sel);
    end
    total++;
    if (led_wen !== wen) begin
      bad++;
      $display("FAIL led_wen: got %b want %b", led_wen, wen);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  sel;
    logic [31:0] val;
    int na, guard;

    do_reset();
    show(6'd5);
    show(6'd8);
    // Give every RAM word a defined value through the normal commit path.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 2'd0, {$urandom_range(0, 3), 20'h0, 8'(i), 2'b11}, 4'h0, 6'd1, 1'b0);
      step(1'b1, 2'd3, $urandom, 4'hF, 6'd2, 1'b0);
    end
    idle(3);

    ld(2'd0, 32'h10);
    cm(32'hDEADBEEF, 4'hF);
    show(6'd3); show(6'd3); show(6'd1);
    cm(32'h11223344, 4'b0101);
    show(6'd3); show(6'd3); show(6'd2);
    cm(32'h55667788, 4'h0);
    show(6'd3); show(6'd3); show(6'd2);

    ld(2'd0, 32'h3F8); cm(32'hA, 4'hF);
    ld(2'd0, 32'h3FC); cm(32'hB, 4'hF);
    ld(2'd0, 32'h000); cm(32'hC, 4'hF);
    ld(2'd0, 32'h004); cm(32'hD, 4'hF);
    ld(2'd2, 32'h3F8);
    idle(SETTLE + 2);
    for (int k = 0; k < W; k++) show(6'(5 + k));
    show(6'd4);

    guard = 0;
    while (phase != 2 && guard < 2 * PERIOD) begin idle(1); guard++; end
    ld(2'd2, 32'h40);
    idle(SETTLE + 2);
    for (int k = 0; k < W; k++) show(6'(5 + k));

    guard = 0;
    while (phase != 2 && guard < 2 * PERIOD) begin idle(1); guard++; end
    do_reset();
    show(6'd5); show(6'd5); show(6'd8); show(6'd7);
    idle(SETTLE + 2);
    for (int k = 0; k < W; k++) show(6'(5 + k));

    ld(2'd0, 32'h0);
    cm(32'h1, 4'hF); cm(32'h2, 4'hF); cm(32'h3, 4'hF);
    show(6'd1);
    for (int k = 0; k < 3; k++) begin
      ld(2'd0, 32'(4 * k)); show(6'd3); show(6'd3);
    end

    for (int r = 0; r < 40; r++) begin
      na = $urandom_range(1, 6);
      repeat (na) begin
        if ($urandom_range(0, 29) == 0) begin
          do_reset();
        end else begin
          sel = 2'($urandom);
          val = $urandom;
          if ((sel == 2'd0 || sel == 2'd2) && $urandom_range(0, 1) == 1)
            val[9:2] = 8'(m_base[9:2] + 8'($urandom_range(0, 5)));
          step(1'b1, sel, val, 4'($urandom), pick_slot(), 1'b0);
        end
      end
      idle($urandom_range(0, 40));
    end

    reset = 1'b0; input_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
